vote_session: RTL

- Parametrised N-voter majority block: the sequential successor to the 3-input combinational voter.
- Runs a timed voting session. Each voter's raw push-key is synchronised and debounced. One vote per voter is latched per session. The tally is compared against a programmable threshold, and the result is held until the next session.
- Sits between the board key inputs and the LED/segment display logic.

---
 rtl/vote_session.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vote_session.sv
// N-voter timed majority session: synchronised, debounced keys feed a one-vote-per-session
// latch; the tally is compared against THRESH and held until the next session opens.
module vote_session #(
  parameter int N_VOTERS   = 3,
  parameter int THRESH     = 2,
  parameter int DEB_CYC    = 1000000,
  parameter int WINDOW_CYC = 500000000,
  localparam int CW        = $clog2(N_VOTERS + 1)
) (
  input  logic                CLK_50M,
  input  logic                RST,
  input  logic                START,
  input  logic [N_VOTERS-1:0] KEY_N,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [N_VOTERS-1:0] VOTED,
  output logic [CW-1:0]       COUNT,
  output logic                TIMEOUT
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int WW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYC - 1);
  localparam logic [CW-1:0] THR      = CW'(THRESH);

  generate
    if (N_VOTERS < 1 || N_VOTERS > 16) begin : g_bad_voters
      $error("vote_session: N_VOTERS must be in 1..16");
    end
    if (THRESH < 0 || THRESH > N_VOTERS) begin : g_bad_thresh
      $error("vote_session: THRESH must be in 0..N_VOTERS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COLLECT, TALLY, RESULT} state_t;

  state_t              state_q, state_d;
  logic [N_VOTERS-1:0] sync_p0, sync_p1, deb_p2, deb_p3;
  logic [DW-1:0]       deb_cnt [N_VOTERS];
  logic [N_VOTERS-1:0] press;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [WW-1:0]       win_cnt;
  logic [CW-1:0]       count_q;
  logic                pass_q, timeout_q, done_q;
  logic                open_session, close_on_expiry;

  function automatic logic [CW-1:0] popcount(input logic [N_VOTERS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Stage p0/p1: two-flop synchroniser on the inverted (active-high) keys
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= ~KEY_N;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2/p3: debounced level and its delayed copy for rising-edge detection
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      deb_p2 <= '0;
      deb_p3 <= '0;
      for (int i = 0; i < N_VOTERS; i++) deb_cnt[i] <= '0;
    end else begin
      deb_p3 <= deb_p2;
      for (int i = 0; i < N_VOTERS; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb_p2[i]  <= ~deb_p2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_p2 & ~deb_p3;

  always_comb begin
    state_d         = state_q;
    open_session    = 1'b0;
    close_on_expiry = 1'b0;
    voted_d         = voted_q | press;
    case (state_q)
      IDLE, RESULT: begin
        if (START) begin
          state_d      = COLLECT;
          open_session = 1'b1;
        end
      end
      COLLECT: begin
        // All-voted takes priority over a simultaneous window expiry
        if (&voted_d) begin
          state_d = TALLY;
        end else if (win_cnt == WIN_LAST) begin
          state_d         = TALLY;
          close_on_expiry = 1'b1;
        end
      end
      TALLY:   state_d = RESULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      voted_q   <= '0;
      win_cnt   <= '0;
      count_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == TALLY);
      if (open_session) begin
        voted_q   <= '0;
        win_cnt   <= '0;
        count_q   <= '0;
        pass_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else if (state_q == COLLECT) begin
        voted_q <= voted_d;
        win_cnt <= win_cnt + 1'b1;
        if (state_d == TALLY) timeout_q <= close_on_expiry;
      end else if (state_q == TALLY) begin
        count_q <= popcount(voted_q);
        pass_q  <= (popcount(voted_q) >= THR);
      end
    end
  end

  assign BUSY    = (state_q == COLLECT) || (state_q == TALLY);
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign VOTED   = voted_q;
  assign COUNT   = count_q;
  assign TIMEOUT = timeout_q;

endmodule
